// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared mode description, standard VGA modes and total-length helper.
//   vga_mode_t      active/porch/sync lengths for both axes
//   MODE_640x480    640x480@60 (25 MHz pixel clock)
//   MODE_800x600    800x600@60 (40 MHz pixel clock)
//   mode_total()    active + front porch + sync + back porch
package vga_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_mode_t;

    localparam vga_mode_t MODE_640x480 = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam vga_mode_t MODE_800x600 = '{800, 40, 128, 88, 600, 1, 4, 23};

    function automatic int mode_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: LAT-stage shift register that advances only when i_shift is high.
//   GCLK     system clock
//   reset    asynchronous, active-high; every stage loads RST_VAL
//   i_shift  advance the pipeline by one stage
//   i_d      value entering the pipeline
//   o_q      value leaving the pipeline, LAT shifts after it entered
module vga_sync_delay #(
    parameter int             LAT     = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         GCLK,
    input  logic         reset,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [LAT];

    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) r_sr[i] <= RST_VAL;
        end else if (i_shift) begin
            r_sr[0] <= i_d;
            for (int i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[LAT-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pixel-rate enable.
//   GCLK, reset        system clock, asynchronous active-high reset
//   en                 run enable; low freezes divider, counters and outputs
//   pix_en             one-GCLK pulse per pixel tick
//   col, row           undelayed scan coordinates (frame-buffer read address)
//   active             undelayed visible-area flag
//   hs, vs, blank      sync and blank, delayed PIPE_LAT pixel ticks to match BRAM latency
//   line_start         pulse with the pix_en that wraps col to 0
//   frame_start        pulse with the pix_en that wraps col and row to 0
//   frame_cnt          completed frames; only counts when VGA_TIMING_FRAME_CNT_EN is defined
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int  CLK_DIV  = 4,
    parameter int  H_ACTIVE = MODE_640x480.h_active,
    parameter int  H_FP     = MODE_640x480.h_fp,
    parameter int  H_SYNC   = MODE_640x480.h_sync,
    parameter int  H_BP     = MODE_640x480.h_bp,
    parameter int  V_ACTIVE = MODE_640x480.v_active,
    parameter int  V_FP     = MODE_640x480.v_fp,
    parameter int  V_SYNC   = MODE_640x480.v_sync,
    parameter int  V_BP     = MODE_640x480.v_bp,
    parameter bit  HS_POL   = 1'b0,
    parameter bit  VS_POL   = 1'b0,
    parameter int  PIPE_LAT = 1,
    parameter int  FCNT_W   = 8,
    localparam int H_TOTAL  = mode_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL  = mode_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int CW       = $clog2(H_TOTAL),
    localparam int RW       = $clog2(V_TOTAL)
) (
    input  logic              GCLK,
    input  logic              reset,
    input  logic              en,
    output logic              pix_en,
    output logic [CW-1:0]     col,
    output logic [RW-1:0]     row,
    output logic              active,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int         DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0] RAW_RST = {~HS_POL, ~VS_POL, 1'b1};

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end
    if (PIPE_LAT > 4) begin : g_bad_lat
        $error("vga_timing_gen: PIPE_LAT must be 0..4");
    end

    logic [DW-1:0] r_div;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_active;
    logic          w_div_end;
    logic          w_col_end;
    logic          w_row_end;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic [2:0]    w_raw;

    assign w_div_end   = r_div == DW'(CLK_DIV - 1);
    assign w_col_end   = r_col == CW'(H_TOTAL - 1);
    assign w_row_end   = r_row == RW'(V_TOTAL - 1);
    assign pix_en      = en && w_div_end;
    assign line_start  = pix_en && w_col_end;
    assign frame_start = line_start && w_row_end;

    always_comb begin
        w_col_nxt = w_col_end ? '0 : r_col + 1'b1;
        w_row_nxt = !w_col_end ? r_row : w_row_end ? '0 : r_row + 1'b1;
    end

    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) r_div <= '0;
        else if (en) r_div <= w_div_end ? '0 : r_div + 1'b1;
    end

    // active is registered from the next coordinates so it can reset to 0
    // while still tracking col/row exactly once the raster is running.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
        end else if (pix_en) begin
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_active <= int'(w_col_nxt) < H_ACTIVE && int'(w_row_nxt) < V_ACTIVE;
        end
    end

    assign col    = r_col;
    assign row    = r_row;
    assign active = r_active;

    assign w_hs_raw = (int'(r_col) >= H_ACTIVE + H_FP && int'(r_col) < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
    assign w_vs_raw = (int'(r_row) >= V_ACTIVE + V_FP && int'(r_row) < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
    assign w_raw    = {w_hs_raw, w_vs_raw, ~r_active};

    if (PIPE_LAT == 0) begin : g_nodelay
        assign {hs, vs, blank} = w_raw;
    end else begin : g_delay
        vga_sync_delay #(.LAT(PIPE_LAT), .W(3), .RST_VAL(RAW_RST)) u_delay (
            .GCLK    (GCLK),
            .reset   (reset),
            .i_shift (pix_en),
            .i_d     (w_raw),
            .o_q     ({hs, vs, blank})
        );
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCNT_W-1:0] r_frame_cnt;

    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) r_frame_cnt <= '0;
        else if (frame_start) r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three differently configured generators checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam vga_mode_t MA = MODE_640x480;
    localparam vga_mode_t MB = '{8, 2, 3, 2, 5, 1, 2, 1};
    localparam vga_mode_t MC = '{6, 1, 2, 1, 4, 1, 1, 1};

    logic GCLK = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    int   e = 0;
    int   tot = 0;
    int   bad = 0;
    logic found;

    logic       pix_a, act_a, hs_a, vs_a, blank_a, ls_a, fs_a;
    logic [9:0] col_a, row_a;
    logic [7:0] fc_a;
    logic       pix_b, act_b, hs_b, vs_b, blank_b, ls_b, fs_b;
    logic [3:0] col_b, row_b;
    logic [1:0] fc_b;
    logic       pix_c, act_c, hs_c, vs_c, blank_c, ls_c, fs_c;
    logic [3:0] col_c;
    logic [2:0] row_c;
    logic [1:0] fc_c;

    always #5 GCLK = ~GCLK;

    always @(posedge GCLK or posedge reset) begin
        if (reset) e <= 0;
        else if (en) e <= e + 1;
    end

    vga_timing_gen u_a (
        .GCLK(GCLK), .reset(reset), .en(en), .pix_en(pix_a), .col(col_a), .row(row_a),
        .active(act_a), .hs(hs_a), .vs(vs_a), .blank(blank_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(MB.h_active), .H_FP(MB.h_fp), .H_SYNC(MB.h_sync), .H_BP(MB.h_bp),
        .V_ACTIVE(MB.v_active), .V_FP(MB.v_fp), .V_SYNC(MB.v_sync), .V_BP(MB.v_bp),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_LAT(2), .FCNT_W(2)
    ) u_b (
        .GCLK(GCLK), .reset(reset), .en(en), .pix_en(pix_b), .col(col_b), .row(row_b),
        .active(act_b), .hs(hs_b), .vs(vs_b), .blank(blank_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(MC.h_active), .H_FP(MC.h_fp), .H_SYNC(MC.h_sync), .H_BP(MC.h_bp),
        .V_ACTIVE(MC.v_active), .V_FP(MC.v_fp), .V_SYNC(MC.v_sync), .V_BP(MC.v_bp),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_LAT(0), .FCNT_W(2)
    ) u_c (
        .GCLK(GCLK), .reset(reset), .en(en), .pix_en(pix_c), .col(col_c), .row(row_c),
        .active(act_c), .hs(hs_c), .vs(vs_c), .blank(blank_c), .line_start(ls_c),
        .frame_start(fs_c), .frame_cnt(fc_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // {hs, vs, blank} as seen on the wires after t pixel ticks; t<=0 is the post-reset state
    function automatic logic [2:0] raw(input vga_mode_t m, input int t, input bit hp, input bit vp);
        int ht = m.h_active + m.h_fp + m.h_sync + m.h_bp;
        int vt = m.v_active + m.v_fp + m.v_sync + m.v_bp;
        int c, r;
        if (t <= 0) return {~hp, ~vp, 1'b1};
        c = t % ht;
        r = (t / ht) % vt;
        return {(c >= m.h_active + m.h_fp && c < m.h_active + m.h_fp + m.h_sync) ? hp : ~hp,
                (r >= m.v_active + m.v_fp && r < m.v_active + m.v_fp + m.v_sync) ? vp : ~vp,
                !(c < m.h_active && r < m.v_active)};
    endfunction

    task automatic check_dut(input string n, input vga_mode_t m, input int div, input int lat,
                             input bit hp, input bit vp, input int fw,
                             input logic [31:0] o_pix, input logic [31:0] o_col, input logic [31:0] o_row,
                             input logic [31:0] o_act, input logic [31:0] o_hs, input logic [31:0] o_vs,
                             input logic [31:0] o_blank, input logic [31:0] o_ls, input logic [31:0] o_fs,
                             input logic [31:0] o_fc);
        int ht = m.h_active + m.h_fp + m.h_sync + m.h_bp;
        int vt = m.v_active + m.v_fp + m.v_sync + m.v_bp;
        int t = e / div;
        int c = t % ht;
        int r = (t / ht) % vt;
        logic pe = en && (e % div == div - 1);
        logic ls = pe && c == ht - 1;
        logic [2:0] d = raw(m, t - lat, hp, vp);
        int fc;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc = (t / (ht * vt)) % (1 << fw);
`else
        fc = 0;
`endif
        chk({n, ".pix_en"}, o_pix, 32'(pe));
        chk({n, ".col"}, o_col, c);
        chk({n, ".row"}, o_row, r);
        chk({n, ".active"}, o_act, 32'(t > 0 && c < m.h_active && r < m.v_active));
        chk({n, ".hs"}, o_hs, 32'(d[2]));
        chk({n, ".vs"}, o_vs, 32'(d[1]));
        chk({n, ".blank"}, o_blank, 32'(d[0]));
        chk({n, ".line_start"}, o_ls, 32'(ls));
        chk({n, ".frame_start"}, o_fs, 32'(ls && r == vt - 1));
        chk({n, ".frame_cnt"}, o_fc, fc);
    endtask

    task automatic check_all();
        check_dut("A", MA, 4, 1, 1'b0, 1'b0, 8, pix_a, col_a, row_a, act_a, hs_a, vs_a, blank_a, ls_a, fs_a, fc_a);
        check_dut("B", MB, 2, 2, 1'b1, 1'b0, 2, pix_b, col_b, row_b, act_b, hs_b, vs_b, blank_b, ls_b, fs_b, fc_b);
        check_dut("C", MC, 1, 0, 1'b0, 1'b1, 2, pix_c, col_c, row_c, act_c, hs_c, vs_c, blank_c, ls_c, fs_c, fc_c);
    endtask

    // fixed reset values, independent of the model
    task automatic check_rst(input string n);
        chk({n, ".A.col"}, col_a, 0);
        chk({n, ".A.row"}, row_a, 0);
        chk({n, ".A.active"}, act_a, 0);
        chk({n, ".A.pix_en"}, pix_a, 0);
        chk({n, ".A.hs"}, hs_a, 1);
        chk({n, ".A.vs"}, vs_a, 1);
        chk({n, ".A.blank"}, blank_a, 1);
        chk({n, ".A.frame_cnt"}, fc_a, 0);
        chk({n, ".B.col"}, col_b, 0);
        chk({n, ".B.hs"}, hs_b, 0);
        chk({n, ".B.vs"}, vs_b, 1);
        chk({n, ".B.blank"}, blank_b, 1);
        chk({n, ".B.frame_cnt"}, fc_b, 0);
        chk({n, ".C.row"}, row_c, 0);
        chk({n, ".C.hs"}, hs_c, 1);
        chk({n, ".C.vs"}, vs_c, 0);
        chk({n, ".C.blank"}, blank_c, 1);
        chk({n, ".C.frame_cnt"}, fc_c, 0);
    endtask

    initial begin
        repeat (3) @(negedge GCLK);
        check_rst("rst0");
        reset = 1'b0;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge GCLK);
            check_all();
            if (col_a == 10'd300) found = 1'b1;
        end
        chk("A.reach300", 32'(found), 1);
        en = 1'b0;
        repeat (50) begin
            @(negedge GCLK);
            check_all();
            chk("A.hold300", col_a, 300);
            chk("A.nopix", pix_a, 0);
        end
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge GCLK);
            check_all();
            if (col_a != 10'd300) found = 1'b1;
        end
        chk("A.resume", col_a, 301);
        repeat (8000) begin
            @(negedge GCLK);
            check_all();
            en = ($urandom_range(0, 9) != 0);
        end
        @(negedge GCLK);
        #2;
        en = 1'b0;
        reset = 1'b1;
        #1;
        check_rst("rst_mid");
        repeat (2) begin
            @(negedge GCLK);
            check_all();
        end
        reset = 1'b0;
        repeat (600) begin
            @(negedge GCLK);
            check_all();
            en = ($urandom_range(0, 3) != 0);
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
